ff_sync_filt: RTL and testbench
===============================

Name: ff_sync_filt

Overview:
- Parametrised multi-channel synchroniser for asynchronous level inputs: an N-stage flop chain per bit, a per-bit stability (glitch) filter, and registered outputs.
- Sits at the boundary where async pins or foreign-domain levels enter a `clk` domain, e.g. JTAG TAP status levels into the system clock.
- Optional per-bit rise/fall strobes replace ad-hoc edge detectors downstream.

Parameters:
- WIDTH, 1, number of independent channels (>=1).
- STAGES, 2, synchroniser chain depth (>=2; elaboration error if less).
- FILTER, 1, consecutive cycles the synchronised value must differ from `out` before `out` updates (>=1; 1 = no filtering).
- RESET_VAL, 0 (WIDTH bits), reset value of every chain flop and of `out`, per bit.

Ports:
- clk  in  1  single clock.
- rst_p  in  1  reset, synchronous, active-high.
- in_async  in  WIDTH  asynchronous level inputs.
- out  out  WIDTH  synchronised, filtered levels (registered).
- rise  out  WIDTH  one-cycle strobe when out bit goes 0->1 (only with FF_SYNC_EDGE_EN).
- fall  out  WIDTH  one-cycle strobe when out bit goes 1->0 (only with FF_SYNC_EDGE_EN).

Behaviour:
- Clocking and reset
  - One clock.
  - Reset is synchronous and active-high on `rst_p`, sampled at posedge `clk`.
- Chain, per bit i
  - s[0] <= in_async[i]; s[k] <= s[k-1] for k = 1..STAGES-1.
  - sync = s[STAGES-1].
  - Chain flops carry the ASYNC_REG attribute.
- Filter, per bit, counter `cnt` of width clog2(FILTER) (min 1)
  - sync == out: cnt <= 0, out holds.
  - sync != out and cnt == FILTER-1: out <= sync, cnt <= 0.
  - sync != out otherwise: cnt <= cnt+1.
  - Any cycle with sync == out restarts the count, so pulses shorter than FILTER cycles at sync are rejected entirely.
- Latency
  - With in_async stable before capture edge 1, `out` shows the new value after edge STAGES+FILTER.
  - Example: STAGES=2, FILTER=1 -> visible after edge 3.
- Channels are fully independent; no cross-bit coherency is guaranteed. Multi-bit buses must be Gray-coded or otherwise handshaken by the user.
- Reset
  - Chain, `out` <= RESET_VAL; `cnt` <= 0; rise/fall <= 0.
  - Reset mid-count abandons the pending change.
- No strobes
  - In the cycle reset is asserted.
  - On the first cycle after deassertion, even if in_async differs from RESET_VAL; such a difference propagates normally later and then strobes.
- Simultaneous events: the counter reaching FILTER-1 in the same cycle that sync returns to equal `out` -> no update, cnt <= 0.

Optional Feature:
- Macro: FF_SYNC_EDGE_EN.
- Defined
  - `rise` and `fall` ports exist, registered alongside `out`.
  - rise[i] = 1 exactly in the cycle where out[i] first shows 1 after being 0; likewise fall[i].
  - Never both set for one bit.
- Undefined
  - `rise` and `fall` ports and their logic are absent.
  - `out` timing is identical.

Decomposition:
- Package `ff_sync_pkg`
  - Constant FF_SYNC_MIN_STAGES = 2.
  - Function for counter width (clog2 with min 1).
  - Filter-state typedef for cnt.
- Sub-module `ff_sync_filt_bit`
  - One channel: chain, counter, out bit, optional edge strobes.
  - Instantiated WIDTH times via generate.

Test Plan:
- STAGES=2, FILTER=1, WIDTH=1: in_async 0->1 just after reset release -> `out`=1 after edge 3, `rise`=1 for exactly that cycle, `fall` stays 0.
- STAGES=3, FILTER=4: in_async high for 3 cycles then low -> `out` stays 0, no strobes. Held high 4+ cycles -> `out`=1 after edge 7.
- WIDTH=4, RESET_VAL=4'b1010: during and after reset with in_async=4'b1010 -> `out`=4'b1010, no strobes. Then in_async=4'b0101 (FILTER=1, STAGES=2) -> `out`=4'b0101 after edge 3, rise=4'b0101, fall=4'b1010 for one cycle.
- FILTER=4: in_async toggles so sync differs 3 cycles, equals 1, differs 4 -> single `out` update at end of the 4-cycle run.
- Reset mid-count: FILTER=8, assert rst_p when cnt=5 -> `out`=RESET_VAL, cnt=0. After release, the change requires a full STAGES+8 cycles again.
- Build without FF_SYNC_EDGE_EN: `rise`/`fall` absent; `out` waveform identical to the first scenario.

Source files
------------

// File: rtl/ff_sync_pkg.sv
// Shared constants, types and helpers for the ff_sync_filt synchroniser.
package ff_sync_pkg;

  localparam int FF_SYNC_MIN_STAGES = 2;

  // Per-cycle decision taken by a channel's stability filter.
  typedef enum logic [1:0] {
    FILT_HOLD   = 2'd0,
    FILT_COUNT  = 2'd1,
    FILT_UPDATE = 2'd2
  } filt_act_e;

  // Stability counter width: clog2(filter), never narrower than one bit.
  function automatic int ff_sync_cnt_width(input int filter);
    return (filter <= 2) ? 1 : $clog2(filter);
  endfunction

endpackage

// File: rtl/ff_sync_filt_if.sv
// Level-signal bundle for ff_sync_filt; rise/fall exist only with FF_SYNC_EDGE_EN.
interface ff_sync_filt_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] in_async;
  logic [WIDTH-1:0] out;

`ifdef FF_SYNC_EDGE_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output in_async, input out, rise, fall);
  modport slave  (input in_async, output out, rise, fall);
`else
  modport master (output in_async, input out);
  modport slave  (input in_async, output out);
`endif

endinterface

// File: rtl/ff_sync_filt_bit.sv
// One synchroniser channel: flop chain, stability filter, registered level
// and, with FF_SYNC_EDGE_EN, registered rise/fall strobes.
module ff_sync_filt_bit
  import ff_sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   FILTER    = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_p,
  input  logic in_async_i,
  output logic out_o
`ifdef FF_SYNC_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int             CW       = ff_sync_cnt_width(FILTER);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

  if (STAGES < FF_SYNC_MIN_STAGES) begin : g_bad_stages
    $error("ff_sync_filt_bit: STAGES must be at least %0d", FF_SYNC_MIN_STAGES);
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("ff_sync_filt_bit: FILTER must be at least 1");
  end

  // The first flop may go metastable; the attribute keeps the chain packed
  // together and out of retiming.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;

  logic          sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  filt_act_e     act;

  assign sync = chain_q[STAGES-1];

  always_comb begin
    act = FILT_HOLD;
    if (sync != out_q) begin
      act = (cnt_q == CNT_LAST) ? FILT_UPDATE : FILT_COUNT;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    unique case (act)
      FILT_COUNT:  cnt_d = cnt_q + CW'(1);
      FILT_UPDATE: out_d = sync;
      default:     ;
    endcase
  end

`ifdef FF_SYNC_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes derive from the update decision, so reset can never produce one.
  assign rise_d = (act == FILT_UPDATE) &&  sync;
  assign fall_d = (act == FILT_UPDATE) && !sync;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which the chain relies on.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      chain_q <= {STAGES{RESET_VAL}};
      cnt_q   <= '0;
      out_q   <= RESET_VAL;
`ifdef FF_SYNC_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      chain_q <= {chain_q[STAGES-2:0], in_async_i};
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef FF_SYNC_EDGE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign out_o  = out_q;
`ifdef FF_SYNC_EDGE_EN
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/ff_sync_filt.sv
// Multi-channel level synchroniser with glitch filter; build with
// FF_SYNC_EDGE_EN to add per-bit rise/fall strobes.
module ff_sync_filt
  import ff_sync_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_p,
  ff_sync_filt_if.slave  bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("ff_sync_filt: WIDTH must be at least 1");
  end
  if (STAGES < FF_SYNC_MIN_STAGES) begin : g_bad_stages
    $error("ff_sync_filt: STAGES must be at least %0d", FF_SYNC_MIN_STAGES);
  end

  logic [WIDTH-1:0] out_w;
`ifdef FF_SYNC_EDGE_EN
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
`endif

  // Channels are independent; multi-bit buses need Gray coding upstream.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_sync_filt_bit #(
      .STAGES    (STAGES),
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .clk        (clk),
      .rst_p      (rst_p),
      .in_async_i (bus.in_async[i]),
      .out_o      (out_w[i])
`ifdef FF_SYNC_EDGE_EN
      ,
      .rise_o     (rise_w[i]),
      .fall_o     (fall_w[i])
`endif
    );
  end

  assign bus.out  = out_w;
`ifdef FF_SYNC_EDGE_EN
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;
`endif

endmodule

// File: tb/tb_ff_sync_filt.sv
// Directed scenarios on several configurations plus a randomized run against
// a sample-history reference model.
module tb_ff_sync_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d, rst_e;

  ff_sync_filt_if #(.WIDTH(1)) if_a ();
  ff_sync_filt_if #(.WIDTH(1)) if_b ();
  ff_sync_filt_if #(.WIDTH(4)) if_c ();
  ff_sync_filt_if #(.WIDTH(1)) if_d ();
  ff_sync_filt_if #(.WIDTH(3)) if_e ();

  ff_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(1), .RESET_VAL(1'b0))
    dut_a (.clk(clk), .rst_p(rst_a), .bus(if_a));
  ff_sync_filt #(.WIDTH(1), .STAGES(3), .FILTER(4), .RESET_VAL(1'b0))
    dut_b (.clk(clk), .rst_p(rst_b), .bus(if_b));
  ff_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER(1), .RESET_VAL(4'b1010))
    dut_c (.clk(clk), .rst_p(rst_c), .bus(if_c));
  ff_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(8), .RESET_VAL(1'b0))
    dut_d (.clk(clk), .rst_p(rst_d), .bus(if_d));
  ff_sync_filt #(.WIDTH(3), .STAGES(3), .FILTER(3), .RESET_VAL(3'b101))
    dut_e (.clk(clk), .rst_p(rst_e), .bus(if_e));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle away from it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for dut_e: out flips once the last FILTER synchronised samples
  // all disagree with it; sync is the input sampled STAGES edges earlier.
  localparam int         E_STAGES = 3;
  localparam int         E_FILTER = 3;
  localparam logic [2:0] E_RST    = 3'b101;

  logic [2:0] m_in_hist[$];
  logic [2:0] m_sync_hist[$];
  logic [2:0] m_out, m_rise, m_fall;

  task automatic model_edge(input logic rst, input logic [2:0] din);
    logic [2:0] s;
    bit         all_diff;
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      m_in_hist.delete();
      repeat (E_STAGES) m_in_hist.push_back(E_RST);
      m_sync_hist.delete();
      m_out = E_RST;
    end else begin
      s = m_in_hist.pop_front();
      m_in_hist.push_back(din);
      m_sync_hist.push_back(s);
      if (m_sync_hist.size() > E_FILTER) void'(m_sync_hist.pop_front());
      for (int b = 0; b < 3; b++) begin
        all_diff = (m_sync_hist.size() == E_FILTER);
        foreach (m_sync_hist[k]) if (m_sync_hist[k][b] == m_out[b]) all_diff = 0;
        if (all_diff) begin
          m_out[b]  = ~m_out[b];
          m_rise[b] = m_out[b];
          m_fall[b] = ~m_out[b];
        end
      end
    end
  endtask

  initial begin
    logic [2:0] mask;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;
    if_a.in_async = 1'b0;
    if_b.in_async = 1'b0;
    if_c.in_async = 4'b1010;
    if_d.in_async = 1'b0;
    if_e.in_async = 3'b101;
    step();
    step();

    check("a_rst_out", 8'(if_a.out), 8'h0);
    check("b_rst_out", 8'(if_b.out), 8'h0);
    check("c_rst_out", 8'(if_c.out), 8'hA);
    check("d_rst_out", 8'(if_d.out), 8'h0);
`ifdef FF_SYNC_EDGE_EN
    check("a_rst_rise", 8'(if_a.rise), 8'h0);
    check("c_rst_rise", 8'(if_c.rise), 8'h0);
    check("c_rst_fall", 8'(if_c.fall), 8'h0);
`endif

    // A: 0->1 right after release, visible after edge 3 with one rise strobe.
    rst_a = 1'b0;
    if_a.in_async = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("a_out_e%0d", e), 8'(if_a.out), 8'(e >= 3));
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("a_rise_e%0d", e), 8'(if_a.rise), 8'(e == 3));
      check($sformatf("a_fall_e%0d", e), 8'(if_a.fall), 8'h0);
`endif
    end

    // B: a 3-cycle pulse is shorter than FILTER=4 and must vanish.
    rst_b = 1'b0;
    if_b.in_async = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) if_b.in_async = 1'b0;
      step();
      check($sformatf("b_short_e%0d", e), 8'(if_b.out), 8'h0);
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("b_short_rise_e%0d", e), 8'(if_b.rise), 8'h0);
`endif
    end
    // B: a held level appears after STAGES+FILTER = 7 edges.
    if_b.in_async = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("b_hold_e%0d", e), 8'(if_b.out), 8'(e >= 7));
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("b_hold_rise_e%0d", e), 8'(if_b.rise), 8'(e == 7));
`endif
    end
    // B: differ 3, agree 1, differ 4 -> one update, at edge 11.
    for (int e = 1; e <= 13; e++) begin
      if_b.in_async = (e == 4) ? 1'b1 : 1'b0;
      step();
      check($sformatf("b_tog_e%0d", e), 8'(if_b.out), 8'(e < 11));
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("b_tog_fall_e%0d", e), 8'(if_b.fall), 8'(e == 11));
      check($sformatf("b_tog_rise_e%0d", e), 8'(if_b.rise), 8'h0);
`endif
    end

    // C: release while input already equals RESET_VAL, then invert all bits.
    rst_c = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      check($sformatf("c_idle_e%0d", e), 8'(if_c.out), 8'hA);
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("c_idle_str_e%0d", e), 8'({if_c.rise, if_c.fall}), 8'h0);
`endif
    end
    if_c.in_async = 4'b0101;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("c_out_e%0d", e), 8'(if_c.out), (e >= 3) ? 8'h5 : 8'hA);
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("c_rise_e%0d", e), 8'(if_c.rise), (e == 3) ? 8'h5 : 8'h0);
      check($sformatf("c_fall_e%0d", e), 8'(if_c.fall), (e == 3) ? 8'hA : 8'h0);
`endif
    end

    // D: input differs from RESET_VAL during reset; no change, no strobe.
    if_d.in_async = 1'b1;
    step();
    check("d_inrst_out", 8'(if_d.out), 8'h0);
`ifdef FF_SYNC_EDGE_EN
    check("d_inrst_rise", 8'(if_d.rise), 8'h0);
`endif
    // D: count to 5 (edge 7), reset, then a full STAGES+FILTER = 10 edges.
    rst_d = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("d_pre_e%0d", e), 8'(if_d.out), 8'h0);
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("d_pre_rise_e%0d", e), 8'(if_d.rise), 8'h0);
`endif
    end
    rst_d = 1'b1;
    step();
    check("d_midrst_out", 8'(if_d.out), 8'h0);
    rst_d = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      step();
      check($sformatf("d_post_e%0d", e), 8'(if_d.out), 8'(e >= 10));
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("d_post_rise_e%0d", e), 8'(if_d.rise), 8'(e == 10));
`endif
    end

    // E: random toggling with sparse resets against the history model.
    for (int n = 0; n < 800; n++) begin
      rst_e = (n < 2) ? 1'b1 : ($urandom_range(0, 79) == 0);
      mask  = 3'($urandom) & 3'($urandom);
      if (n[6]) mask = mask & 3'($urandom);
      if_e.in_async = if_e.in_async ^ mask;
      model_edge(rst_e, if_e.in_async);
      step();
      check($sformatf("e_out_n%0d", n), 8'(if_e.out), 8'(m_out));
`ifdef FF_SYNC_EDGE_EN
      check($sformatf("e_rise_n%0d", n), 8'(if_e.rise), 8'(m_rise));
      check($sformatf("e_fall_n%0d", n), 8'(if_e.fall), 8'(m_fall));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
